issue_stage: RTL and testbench

ISSUE_STAGE -- requirements
Module: issue_stage

---
 rtl/issue_stage.sv | 142 ++++++++++++++
 tb/tb_issue_stage.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/issue_stage.sv
// ============================================================================
// Module   : issue_stage
// Brief    : 2-entry fetch buffer, 16x16 regfile and scoreboard-based in-order
//            issue to the ALU; optional writeback bypass via ISSUE_BYPASS_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module issue_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        f_valid,
  output logic        f_ready,
  input  logic [15:0] f_instr,
  input  logic [15:0] f_pc,
  input  logic        wb_en,
  input  logic [3:0]  wb_addr,
  input  logic [15:0] wb_data,
  input  logic        br_taken,
  output logic [15:0] iss_instr,
  output logic [15:0] iss_pc,
  output logic [15:0] iss_rs1_data,
  output logic [15:0] iss_rs2_data,
  output logic        iss_valid
);

  logic [15:0] fifo_instr_q [2];
  logic [15:0] fifo_pc_q    [2];
  logic        rd_ptr_q, wr_ptr_q, rd_ptr_d, wr_ptr_d;
  logic [1:0]  count_q, count_d;
  logic [15:0] rf_q [16];
  logic [15:0] sb_q, sb_d;
  logic [1:0]  mul_cnt_q, mul_cnt_d;
  logic [15:0] iss_instr_q, iss_pc_q, iss_rs1_q, iss_rs2_q;
  logic        iss_valid_q;

  logic [15:0] head_instr, head_pc;
  logic [3:0]  op, rd, rs1, rs2, dest;
  logic        writes, uses_rs2, hazard, can_issue, push;
  logic [15:0] wb_mask, set_mask, sb_view, rs1_val, rs2_val;

  assign head_instr = fifo_instr_q[rd_ptr_q];
  assign head_pc    = fifo_pc_q[rd_ptr_q];
  assign op         = head_instr[15:12];
  assign rd         = head_instr[11:8];
  assign rs2        = head_instr[7:4];
  assign rs1        = head_instr[3:0];
  assign writes     = (op != 4'hD);
  assign dest       = (op == 4'hE) ? 4'hF : rd;
  assign uses_rs2   = (op <= 4'h5) || (op == 4'hD);
  assign wb_mask    = wb_en ? (16'h0001 << wb_addr) : 16'h0000;

`ifdef ISSUE_BYPASS_EN
  assign sb_view = sb_q & ~wb_mask;
`else
  assign sb_view = sb_q;
`endif

  function automatic logic [15:0] read_reg(input logic [3:0] a);
    logic [15:0] v;
    v = (a == 4'h0) ? 16'h0000 : rf_q[a];
`ifdef ISSUE_BYPASS_EN
    if (wb_en && (wb_addr == a) && (a != 4'h0)) v = wb_data;
`endif
    return v;
  endfunction

  assign rs1_val = read_reg(rs1);
  assign rs2_val = read_reg(rs2);

  assign hazard    = sb_view[rs1] | (uses_rs2 & sb_view[rs2]) | (writes & sb_view[dest]);
  assign can_issue = (count_q != 2'd0) && !hazard && (mul_cnt_q == 2'd0) && !br_taken;
  assign f_ready   = rst_n && (count_q != 2'd2);
  assign push      = f_valid && f_ready && !br_taken;
  assign set_mask  = (can_issue && writes && (dest != 4'h0)) ? (16'h0001 << dest) : 16'h0000;

  always_comb begin
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    mul_cnt_d = mul_cnt_q;
    // Issue-set is OR'ed after the clear so a same-register collision stays busy.
    sb_d      = (sb_q & ~wb_mask) | set_mask;
    if (br_taken) begin
      rd_ptr_d  = 1'b0;
      wr_ptr_d  = 1'b0;
      count_d   = 2'd0;
      mul_cnt_d = 2'd0;
    end else begin
      if (push)      wr_ptr_d = ~wr_ptr_q;
      if (can_issue) rd_ptr_d = ~rd_ptr_q;
      count_d = count_q + {1'b0, push} - {1'b0, can_issue};
      if (can_issue && (op == 4'h5)) mul_cnt_d = 2'd2;
      else if (mul_cnt_q != 2'd0)    mul_cnt_d = mul_cnt_q - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        fifo_instr_q[i] <= '0;
        fifo_pc_q[i]    <= '0;
      end
      for (int i = 0; i < 16; i++) rf_q[i] <= '0;
      rd_ptr_q    <= 1'b0;
      wr_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
      sb_q        <= '0;
      mul_cnt_q   <= 2'd0;
      iss_instr_q <= '0;
      iss_pc_q    <= '0;
      iss_rs1_q   <= '0;
      iss_rs2_q   <= '0;
      iss_valid_q <= 1'b0;
    end else begin
      if (push) begin
        fifo_instr_q[wr_ptr_q] <= f_instr;
        fifo_pc_q[wr_ptr_q]    <= f_pc;
      end
      if (wb_en && (wb_addr != 4'h0)) rf_q[wb_addr] <= wb_data;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      sb_q        <= sb_d;
      mul_cnt_q   <= mul_cnt_d;
      iss_instr_q <= can_issue ? head_instr : 16'h0000;
      iss_pc_q    <= can_issue ? head_pc    : 16'h0000;
      iss_rs1_q   <= can_issue ? rs1_val    : 16'h0000;
      iss_rs2_q   <= can_issue ? rs2_val    : 16'h0000;
      iss_valid_q <= can_issue;
    end
  end

  assign iss_instr    = iss_instr_q;
  assign iss_pc       = iss_pc_q;
  assign iss_rs1_data = iss_rs1_q;
  assign iss_rs2_data = iss_rs2_q;
  assign iss_valid    = iss_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_issue_stage.sv
// ============================================================================
// Module   : tb_issue_stage
// Brief    : Directed self-checking bench for issue_stage.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_issue_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        f_valid, f_ready;
  logic [15:0] f_instr, f_pc;
  logic        wb_en;
  logic [3:0]  wb_addr;
  logic [15:0] wb_data;
  logic        br_taken;
  logic [15:0] iss_instr, iss_pc, iss_rs1_data, iss_rs2_data;
  logic        iss_valid;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  issue_stage dut (
    .clk(clk), .rst_n(rst_n),
    .f_valid(f_valid), .f_ready(f_ready), .f_instr(f_instr), .f_pc(f_pc),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .br_taken(br_taken),
    .iss_instr(iss_instr), .iss_pc(iss_pc),
    .iss_rs1_data(iss_rs1_data), .iss_rs2_data(iss_rs2_data),
    .iss_valid(iss_valid)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] instr, input logic [15:0] pc);
    f_valid = 1'b1;
    f_instr = instr;
    f_pc    = pc;
    tick();
    f_valid = 1'b0;
  endtask

  task automatic wb(input logic [3:0] a, input logic [15:0] d);
    wb_en   = 1'b1;
    wb_addr = a;
    wb_data = d;
    tick();
    wb_en   = 1'b0;
  endtask

  logic [9:0]  mul_exp_valid;
  logic [15:0] got_pc  [8];
  logic [15:0] got_rs1 [8];
  int          n_iss;
  int          n_push;
  int          mul_k;
  logic        acc, d_acc;

  initial begin
    rst_n = 1'b0; f_valid = 1'b0; f_instr = '0; f_pc = '0;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0; br_taken = 1'b0;
    #3;
    check("rst_f_ready",   {31'b0, f_ready},   32'd0);
    check("rst_iss_valid", {31'b0, iss_valid}, 32'd0);
    check("rst_iss_instr", {16'b0, iss_instr}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("post_rst_f_ready", {31'b0, f_ready}, 32'd1);

    // r1=5, r2=7, then basic add
    wb(4'd1, 16'd5);
    wb(4'd2, 16'd7);
    push(16'h0312, 16'h0100);
    check("add_lat1_valid", {31'b0, iss_valid}, 32'd0);
    tick();
    check("add_valid", {31'b0, iss_valid},    32'd1);
    check("add_instr", {16'b0, iss_instr},    32'h0312);
    check("add_pc",    {16'b0, iss_pc},       32'h0100);
    check("add_rs1",   {16'b0, iss_rs1_data}, 32'd7);
    check("add_rs2",   {16'b0, iss_rs2_data}, 32'd5);

    // RAW on r3
    push(16'h0433, 16'h0102);
    check("raw_e0_valid", {31'b0, iss_valid}, 32'd0);
    tick();
    check("raw_e1_valid", {31'b0, iss_valid}, 32'd0);
    wb(4'd3, 16'd12);
`ifdef ISSUE_BYPASS_EN
    check("raw_bypass_valid", {31'b0, iss_valid}, 32'd1);
`else
    check("raw_nobyp_stall", {31'b0, iss_valid}, 32'd0);
    tick();
    check("raw_nobyp_valid", {31'b0, iss_valid}, 32'd1);
`endif
    check("raw_instr", {16'b0, iss_instr},    32'h0433);
    check("raw_rs1",   {16'b0, iss_rs1_data}, 32'd12);
    check("raw_rs2",   {16'b0, iss_rs2_data}, 32'd12);
    wb(4'd4, 16'h0055);

    // three back-to-back muls
    mul_exp_valid = 10'b0010010010;
    n_push = 0;
    mul_k  = 0;
    for (int c = 0; c < 10; c++) begin
      f_valid = (n_push < 3);
      f_instr = 16'h5021;
      f_pc    = 16'h0200 + 16'(2 * n_push);
      acc     = f_valid && f_ready;
      tick();
      if (acc) n_push++;
      check($sformatf("mul_valid_%0d", c), {31'b0, iss_valid}, {31'b0, mul_exp_valid[c]});
      if (mul_exp_valid[c]) begin
        check($sformatf("mul_pc_%0d", mul_k), {16'b0, iss_pc}, 32'h0200 + 32'(2 * mul_k));
        check($sformatf("mul_rs1_%0d", mul_k), {16'b0, iss_rs1_data}, 32'd5);
        mul_k++;
      end
    end
    f_valid = 1'b0;
    check("mul_pushed", n_push, 3);

    // full FIFO held by a stall, then drained in order
    push(16'h0612, 16'h0300);
    push(16'h0766, 16'h0302);
    push(16'h0021, 16'h0304);
    check("full_f_ready", {31'b0, f_ready}, 32'd0);
    f_valid = 1'b1; f_instr = 16'h0012; f_pc = 16'h0306;
    tick();
    check("full_f_ready2", {31'b0, f_ready},   32'd0);
    check("full_stall",    {31'b0, iss_valid}, 32'd0);
    n_iss = 0;
    d_acc = 1'b0;
    for (int c = 0; c < 10; c++) begin
      wb_en   = (c == 0);
      wb_addr = 4'd6;
      wb_data = 16'h0ABC;
      f_valid = !d_acc;
      acc     = f_valid && f_ready;
      tick();
      if (acc) d_acc = 1'b1;
      if (iss_valid && n_iss < 8) begin
        got_pc[n_iss]  = iss_pc;
        got_rs1[n_iss] = iss_rs1_data;
        n_iss++;
      end
    end
    wb_en = 1'b0; f_valid = 1'b0;
    check("full_d_accepted", {31'b0, d_acc}, 32'd1);
    check("full_n_issued",   n_iss, 3);
    if (n_iss == 3) begin
      check("full_order0", {16'b0, got_pc[0]},  32'h0302);
      check("full_order1", {16'b0, got_pc[1]},  32'h0304);
      check("full_order2", {16'b0, got_pc[2]},  32'h0306);
      check("full_b_rs1",  {16'b0, got_rs1[0]}, 32'h0ABC);
    end

    // branch flush with two buffered entries and f_valid high
    push(16'h0612, 16'h0400);
    push(16'h0766, 16'h0402);
    push(16'h0021, 16'h0404);
    check("br_pre_full", {31'b0, f_ready}, 32'd0);
    br_taken = 1'b1; f_valid = 1'b1; f_instr = 16'h0012; f_pc = 16'h0406;
    tick();
    br_taken = 1'b0; f_valid = 1'b0;
    check("br_bubble",  {31'b0, iss_valid}, 32'd0);
    check("br_f_ready", {31'b0, f_ready},   32'd1);
    push(16'h0021, 16'h0410);
    tick();
    check("br_after_valid", {31'b0, iss_valid}, 32'd1);
    check("br_after_pc",    {16'b0, iss_pc},    32'h0410);

    // asynchronous reset mid-stall
    push(16'h0021, 16'h0500);
    push(16'h0766, 16'h0502);
    check("pre_rst_valid", {31'b0, iss_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid",   {31'b0, iss_valid}, 32'd0);
    check("mid_rst_pc",      {16'b0, iss_pc},    32'h0);
    check("mid_rst_f_ready", {31'b0, f_ready},   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("rel_rst_valid", {31'b0, iss_valid}, 32'd0);
    push(16'h0766, 16'h0600);
    tick();
    check("post_rst_issue", {31'b0, iss_valid},    32'd1);
    check("post_rst_pc",    {16'b0, iss_pc},       32'h0600);
    check("post_rst_rs1",   {16'b0, iss_rs1_data}, 32'h0);

    // r0 stays zero after a write attempt
    wb(4'd0, 16'hFFFF);
    push(16'h0D00, 16'h0700);
    tick();
    check("r0_valid", {31'b0, iss_valid},    32'd1);
    check("r0_rs1",   {16'b0, iss_rs1_data}, 32'h0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
